// File: rtl/w0rm_alu_pkg.sv
// Shared definitions for the w0rm shift unit: opcode encodings and flag layout.
// The rotate opcodes only do anything when W0RM_ALU_SHIFTS_ROTATE_EN is defined.
package w0rm_alu_pkg;

  typedef enum logic [3:0] {
    OP_LSL = 4'd0,
    OP_LSR = 4'd1,
    OP_ASR = 4'd2,
    OP_ROR = 4'd3,
    OP_ROL = 4'd4
  } shift_op_e;

  localparam int unsigned FLAGS_WIDTH = 4;
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/w0rm_barrel_shifter.sv
// Combinational barrel shifter: value shifted by an unsigned amount, plus the
// carry-out (last bit shifted out or wrapped). op_ok is low for unknown opcodes.
// Rotates exist only when W0RM_ALU_SHIFTS_ROTATE_EN is defined.
module w0rm_barrel_shifter
  import w0rm_alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] amount,
  input  logic [3:0]   op,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         op_ok
);

  localparam int unsigned AW = $clog2(W);
  localparam logic [W-1:0] W_VAL = W'(W);

  logic [AW-1:0] sh;
  logic          big;
  logic          exact;
  logic [W:0]    lsl_ext;
  logic [W:0]    lsr_ext;
  logic [W:0]    asr_ext;
`ifdef W0RM_ALU_SHIFTS_ROTATE_EN
  logic          zero_amt;
  logic [2*W-1:0] ror_ext;
  logic [2*W-1:0] rol_ext;
`endif

  assign sh    = amount[AW-1:0];
  assign big   = (amount >= W_VAL);
  assign exact = (amount == W_VAL);

  // Each shift is done one bit wider than the data so the spare bit catches
  // the last bit shifted out; an in-range amount of 0 leaves that bit at 0.
  always_comb begin
    lsl_ext = {1'b0, value} << sh;
    lsr_ext = {value, 1'b0} >> sh;
    asr_ext = $unsigned($signed({value, 1'b0}) >>> sh);
`ifdef W0RM_ALU_SHIFTS_ROTATE_EN
    zero_amt = (amount == '0);
    ror_ext  = {value, value} >> sh;
    rol_ext  = {value, value} << sh;
`endif
    result = '0;
    carry  = 1'b0;
    op_ok  = 1'b1;
    case (op)
      OP_LSL: begin
        if (big) begin
          result = '0;
          carry  = exact ? value[W-1] : 1'b0;
        end else begin
          result = lsl_ext[W-1:0];
          carry  = lsl_ext[W];
        end
      end
      OP_LSR: begin
        if (big) begin
          result = '0;
          carry  = exact ? value[0] : 1'b0;
        end else begin
          result = lsr_ext[W:1];
          carry  = lsr_ext[0];
        end
      end
      OP_ASR: begin
        if (big) begin
          result = {W{value[W-1]}};
          carry  = value[W-1];
        end else begin
          result = asr_ext[W:1];
          carry  = asr_ext[0];
        end
      end
`ifdef W0RM_ALU_SHIFTS_ROTATE_EN
      OP_ROR: begin
        result = ror_ext[W-1:0];
        carry  = !zero_amt && result[W-1];
      end
      OP_ROL: begin
        result = rol_ext[2*W-1:W];
        carry  = !zero_amt && result[0];
      end
`endif
      default: op_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/w0rm_alu_shifts.sv
// Shift ALU slice: barrel shifter, Z/N/C/V flag generation and an optional
// single-stage output register (SINGLE_CYCLE=0). Rotates are enabled by
// defining W0RM_ALU_SHIFTS_ROTATE_EN; otherwise opcodes 3/4 act as undefined.
module w0rm_alu_shifts
  import w0rm_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SINGLE_CYCLE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_valid,
  input  logic [3:0]             opcode,
  input  logic [DATA_WIDTH-1:0]  data_a,
  input  logic [DATA_WIDTH-1:0]  data_b,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   result_valid,
  output logic [FLAGS_WIDTH-1:0] result_flags
);

  logic [DATA_WIDTH-1:0]  sh_result;
  logic                   sh_carry;
  logic                   sh_ok;
  logic [DATA_WIDTH-1:0]  comb_result;
  logic [FLAGS_WIDTH-1:0] comb_flags;

  w0rm_barrel_shifter #(
    .W (DATA_WIDTH)
  ) u_shifter (
    .value  (data_a),
    .amount (data_b),
    .op     (opcode),
    .result (sh_result),
    .carry  (sh_carry),
    .op_ok  (sh_ok)
  );

  // Flags from the shifter result; undefined opcodes force result and flags to 0.
  always_comb begin
    comb_result = '0;
    comb_flags  = '0;
    if (sh_ok) begin
      comb_result          = sh_result;
      comb_flags[FLAG_Z]   = (sh_result == '0);
      comb_flags[FLAG_N]   = sh_result[DATA_WIDTH-1];
      comb_flags[FLAG_C]   = sh_carry;
      comb_flags[FLAG_V]   = 1'b0;
    end
  end

  if (SINGLE_CYCLE != 0) begin : g_comb
    assign result       = comb_result;
    assign result_flags = comb_flags;
    assign result_valid = data_valid;
  end else begin : g_reg
    // Output register: capture on each request, hold otherwise; valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        result       <= '0;
        result_flags <= '0;
        result_valid <= 1'b0;
      end else begin
        result_valid <= data_valid;
        if (data_valid) begin
          result       <= comb_result;
          result_flags <= comb_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_w0rm_alu_shifts.sv
// Scoreboard bench for w0rm_alu_shifts (DATA_WIDTH=8, SINGLE_CYCLE=0).
// Expected values are hand-computed; rotate expectations follow
// W0RM_ALU_SHIFTS_ROTATE_EN.
module tb_w0rm_alu_shifts;

  logic       clk;
  logic       rst_n;
  logic       data_valid;
  logic [3:0] opcode;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] result;
  logic       result_valid;
  logic [3:0] result_flags;

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  w0rm_alu_shifts #(
    .DATA_WIDTH   (8),
    .SINGLE_CYCLE (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_valid   (data_valid),
    .opcode       (opcode),
    .data_a       (data_a),
    .data_b       (data_b),
    .result       (result),
    .result_valid (result_valid),
    .result_flags (result_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags are {V,C,N,Z}.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [3:0] ef, input string name);
    exp_t e;
    @(negedge clk);
    data_valid = 1'b1;
    opcode     = op;
    data_a     = a;
    data_b     = b;
    e.r = er;
    e.f = ef;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] er,
                           input logic [3:0] ef, input logic ev);
    checks++;
    if (result !== er || result_flags !== ef || result_valid !== ev) begin
      failures++;
      $display("FAIL %s: got result=%02h flags=%04b valid=%b, want result=%02h flags=%04b valid=%b",
               name, result, result_flags, result_valid, er, ef, ev);
    end
  endtask

  // Monitor: every result_valid cycle must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (result_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: got result=%02h flags=%04b, want no result_valid",
                 result, result_flags);
      end else begin
        e = exp_q.pop_front();
        if (result !== e.r || result_flags !== e.f) begin
          failures++;
          $display("FAIL %s: got result=%02h flags=%04b, want result=%02h flags=%04b",
                   e.name, result, result_flags, e.r, e.f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    opcode     = '0;
    data_a     = '0;
    data_b     = '0;
    repeat (2) @(negedge clk);
    check_out("reset_state", 8'h00, 4'b0000, 1'b0);
    rst_n = 1'b1;

    // Directed vectors
    issue(4'd0, 8'h81, 8'd1,   8'h02, 4'b0100, "lsl_81_1");
    issue(4'd1, 8'h01, 8'd1,   8'h00, 4'b0101, "lsr_01_1");
    issue(4'd1, 8'hFF, 8'd9,   8'h00, 4'b0001, "lsr_ff_9");
    issue(4'd2, 8'h80, 8'd3,   8'hF0, 4'b0010, "asr_80_3");
    issue(4'd2, 8'h80, 8'd8,   8'hFF, 4'b0110, "asr_80_8");
    issue(4'd0, 8'h81, 8'd0,   8'h81, 4'b0010, "lsl_amount0");
    issue(4'd0, 8'hFF, 8'd200, 8'h00, 4'b0001, "lsl_big");
    issue(4'd2, 8'h7F, 8'd20,  8'h00, 4'b0001, "asr_pos_big");
    issue(4'd1, 8'h88, 8'd4,   8'h08, 4'b0100, "lsr_88_4");
    issue(4'd7, 8'h55, 8'd1,   8'h00, 4'b0000, "undef_op7");
`ifdef W0RM_ALU_SHIFTS_ROTATE_EN
    issue(4'd3, 8'h01, 8'd1,   8'h80, 4'b0110, "ror_01_1");
    issue(4'd4, 8'h80, 8'd1,   8'h01, 4'b0100, "rol_80_1");
    issue(4'd3, 8'h12, 8'd12,  8'h21, 4'b0000, "ror_12_12");
`else
    issue(4'd3, 8'h01, 8'd1,   8'h00, 4'b0000, "ror_disabled");
    issue(4'd4, 8'h80, 8'd1,   8'h00, 4'b0000, "rol_disabled");
`endif
    idle(2);

    // Back-to-back LSL of 0x01 by 0..7
    for (int unsigned i = 0; i < 8; i++) begin
      logic [7:0] er;
      logic [3:0] ef;
      er = 8'h01 << i;
      ef = (i == 7) ? 4'b0010 : 4'b0000;
      issue(4'd0, 8'h01, 8'(i), er, ef, $sformatf("b2b_lsl_%0d", i));
    end
    idle(3);
    check_out("hold_after_idle", 8'h80, 4'b0010, 1'b0);

    // Load a known nonzero result, then reset with a request pending.
    issue(4'd2, 8'h80, 8'd3, 8'hF0, 4'b0010, "asr_before_reset");
    @(negedge clk);
    data_valid = 1'b1;
    opcode     = 4'd0;
    data_a     = 8'h0F;
    data_b     = 8'd1;
    #2;
    check_out("pre_reset_value", 8'hF0, 4'b0010, 1'b1);
    rst_n = 1'b0;
    #1;
    check_out("async_reset_clear", 8'h00, 4'b0000, 1'b0);
    @(negedge clk);
    data_valid = 1'b0;
    rst_n = 1'b1;
    idle(3);
    check_out("post_reset_quiet", 8'h00, 4'b0000, 1'b0);

    // First request right after release
    issue(4'd0, 8'h40, 8'd2, 8'h00, 4'b0101, "first_after_reset");
    idle(1);

    // Bounded drain of the scoreboard
    for (int unsigned i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
